capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_pkg.sv | 23 ++
 rtl/capture_ctrl_post_counter.sv | 42 ++++
 rtl/capture_ctrl.sv | 131 +++++++++++++
 tb/tb_capture_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared definitions for the capture controller: FSM state encodings,
// record field offsets and the default record width.
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_TRIG  = 2'b10,
        ST_DONE  = 2'b11
    } cap_state_t;

    localparam int DEFAULT_DW = 48;

    // Record layout
    localparam int CYC_LSB  = 0;
    localparam int CYC_W    = 4;
    localparam int TMO_BIT  = 4;
    localparam int DATA_LSB = 8;
    localparam int ADDR_LSB = 16;

    localparam int CNT_W = 16;

endpackage

// File: rtl/capture_ctrl_post_counter.sv
// Post-trigger record counter: load, decrement, and a flag telling the
// controller that the next decrement brings the count to zero.
module post_counter
    import capture_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             one_left
);

    logic [CNT_W-1:0] count_next;

    // Load takes priority over clear so a record arriving with arm can
    // still load the counter against the freshly armed state.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_value;
        end else if (clear) begin
            count_next = '0;
        end else if (dec && (count != '0)) begin
            count_next = count - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign one_left = (count == CNT_W'(1));

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: arms on request, forwards records to the ring buffer
// until POST_COUNT records after the trigger record, counts records
// discarded while idle or done.
// Optional feature: define CAPTURE_FILTER_EN to ignore records whose
// cycle type is not enabled in CYC_MASK.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int          DW         = DEFAULT_DW,
    parameter int          POST_COUNT = 512,
    parameter logic [15:0] CYC_MASK   = 16'hFFFF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arm,
    input  logic          abort,
    input  logic [DW-1:0] in_data,
    input  logic          in_enable,
    input  logic          trigger,
    output logic [DW-1:0] out_data,
    output logic          out_enable,
    output logic [1:0]    state,
    output logic [15:0]   dropped
);

    cap_state_t       cur_state, nxt_state, eff_state;
    logic             rec_valid;
    logic             fwd;
    logic             cnt_clear, cnt_load, cnt_dec, one_left;
    logic             drop_inc, drop_clear;
    logic [CNT_W-1:0] post_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef CAPTURE_FILTER_EN
    assign rec_valid = in_enable & CYC_MASK[in_data[CYC_LSB +: CYC_W]];
`else
    assign rec_valid = in_enable;
`endif

    post_counter u_post_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (CNT_W'(POST_COUNT)),
        .dec        (cnt_dec),
        .count      (post_cnt),
        .one_left   (one_left)
    );

    // Next state: abort/arm first redefine the state the current record is
    // judged against, then the record itself is processed.
    always_comb begin
        nxt_state  = cur_state;
        eff_state  = cur_state;
        fwd        = 1'b0;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        drop_inc   = 1'b0;
        drop_clear = 1'b0;
        if (abort) begin
            eff_state = ST_IDLE;
            nxt_state = ST_IDLE;
            cnt_clear = 1'b1;
        end else if (arm) begin
            eff_state  = ST_ARMED;
            nxt_state  = ST_ARMED;
            cnt_clear  = 1'b1;
            drop_clear = 1'b1;
        end
        if (rec_valid) begin
            case (eff_state)
                ST_ARMED: begin
                    fwd = 1'b1;
                    if (trigger) begin
                        cnt_load  = 1'b1;
                        nxt_state = (POST_COUNT == 0) ? ST_DONE : ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    fwd     = 1'b1;
                    cnt_dec = 1'b1;
                    if (one_left || (post_cnt == '0)) begin
                        nxt_state = ST_DONE;
                    end
                end
                default: drop_inc = 1'b1;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Registered forward path to the ring buffer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_enable <= 1'b0;
            out_data   <= '0;
        end else begin
            out_enable <= fwd;
            if (fwd) begin
                out_data <= in_data;
            end
        end
    end

    // Saturating count of discarded records
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dropped <= '0;
        end else if (drop_clear) begin
            dropped <= '0;
        end else if (drop_inc) begin
            dropped <= sat_inc(dropped);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl. Two instances share stimulus:
// dut (POST_COUNT=2) and dut0 (POST_COUNT=0). Forwarded records are checked
// against a scoreboard holding expected data and arrival cycle.
module tb_capture_ctrl;

    logic        clock;
    logic        reset;
    logic        arm;
    logic        abort;
    logic [47:0] in_data;
    logic        in_enable;
    logic        trigger;
    logic [47:0] out_data, out_data0;
    logic        out_enable, out_enable0;
    logic [1:0]  state, state0;
    logic [15:0] dropped, dropped0;

    typedef struct {
        logic [47:0] d;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    exp_t e, e0;
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    bit   mon_en  = 1'b1;
    bit   mon0_en = 1'b0;

    capture_ctrl #(.DW(48), .POST_COUNT(2), .CYC_MASK(16'h0004)) dut (
        .clock(clock), .reset(reset), .arm(arm), .abort(abort),
        .in_data(in_data), .in_enable(in_enable), .trigger(trigger),
        .out_data(out_data), .out_enable(out_enable), .state(state),
        .dropped(dropped)
    );

    capture_ctrl #(.DW(48), .POST_COUNT(0), .CYC_MASK(16'h0004)) dut0 (
        .clock(clock), .reset(reset), .arm(arm), .abort(abort),
        .in_data(in_data), .in_enable(in_enable), .trigger(trigger),
        .out_data(out_data0), .out_enable(out_enable0), .state(state0),
        .dropped(dropped0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitors
    always @(negedge clock) begin
        if (mon_en && out_enable === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_fwd got data=%h cyc=%0d, none expected", out_data, cyc);
            end else begin
                e = q.pop_front();
                if (out_data !== e.d || cyc != e.due)
                    $display("FAIL fwd_record got data=%h cyc=%0d want data=%h cyc=%0d",
                             out_data, cyc, e.d, e.due);
                else
                    passed++;
            end
        end
        if (mon0_en && out_enable0 === 1'b1) begin
            total++;
            if (q0.size() == 0) begin
                $display("FAIL unexpected_fwd0 got data=%h cyc=%0d, none expected", out_data0, cyc);
            end else begin
                e0 = q0.pop_front();
                if (out_data0 !== e0.d || cyc != e0.due)
                    $display("FAIL fwd_record0 got data=%h cyc=%0d want data=%h cyc=%0d",
                             out_data0, cyc, e0.d, e0.due);
                else
                    passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rec(input logic [47:0] d, input logic t, input bit fwd, input bit fwd0);
        exp_t x;
        in_data   = d;
        trigger   = t;
        in_enable = 1'b1;
        x.d   = d;
        x.due = cyc + 1;
        if (fwd && mon_en) q.push_back(x);
        if (fwd0 && mon0_en) q0.push_back(x);
        tick();
        in_enable = 1'b0;
        trigger   = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        total++; if (state !== 2'b00) $display("FAIL reset_state got %b want 00", state); else passed++;
        total++; if (out_enable !== 1'b0) $display("FAIL reset_out_enable got %b want 0", out_enable); else passed++;
        total++; if (out_data !== 48'h0) $display("FAIL reset_out_data got %h want 0", out_data); else passed++;
        total++; if (dropped !== 16'h0) $display("FAIL reset_dropped got %h want 0", dropped); else passed++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_idle_drop();
        for (int i = 0; i < 3; i++) rec(48'h1000_0000_0002 + 48'(i), 1'b0, 1'b0, 1'b0);
        tick();
        total++; if (dropped !== 16'd3) $display("FAIL idle_dropped got %0d want 3", dropped); else passed++;
        total++; if (state !== 2'b00) $display("FAIL idle_state got %b want 00", state); else passed++;
    endtask

    task automatic test_capture();
        pulse_arm();
        total++; if (state !== 2'b01) $display("FAIL cap_armed got %b want 01", state); else passed++;
        total++; if (dropped !== 16'd0) $display("FAIL cap_arm_clear got %0d want 0", dropped); else passed++;
        rec(48'hA000_0001_1101, 1'b0, 1'b1, 1'b0);
        total++; if (state !== 2'b01) $display("FAIL cap_pre_trig got %b want 01", state); else passed++;
        rec(48'hA000_0002_2202, 1'b1, 1'b1, 1'b0);
        total++; if (state !== 2'b10) $display("FAIL cap_trig got %b want 10", state); else passed++;
        rec(48'hA000_0003_3303, 1'b0, 1'b1, 1'b0);
        total++; if (state !== 2'b10) $display("FAIL cap_post1 got %b want 10", state); else passed++;
        rec(48'hA000_0004_4404, 1'b0, 1'b1, 1'b0);
        total++; if (state !== 2'b11) $display("FAIL cap_done got %b want 11", state); else passed++;
        rec(48'hA000_0005_5505, 1'b0, 1'b0, 1'b0);
        tick();
        total++; if (dropped !== 16'd1) $display("FAIL cap_done_drop got %0d want 1", dropped); else passed++;
        total++; if (q.size() != 0) $display("FAIL cap_missing got %0d pending want 0", q.size()); else passed++;
    endtask

    task automatic test_post0();
        pulse_abort();
        tick();
        mon_en  = 1'b0;
        mon0_en = 1'b1;
        pulse_arm();
        rec(48'hB000_0001_0001, 1'b1, 1'b0, 1'b1);
        total++; if (state0 !== 2'b11) $display("FAIL post0_done got %b want 11", state0); else passed++;
        rec(48'hB000_0002_0002, 1'b0, 1'b0, 1'b0);
        tick();
        total++; if (dropped0 !== 16'd1) $display("FAIL post0_drop got %0d want 1", dropped0); else passed++;
        total++; if (q0.size() != 0) $display("FAIL post0_missing got %0d pending want 0", q0.size()); else passed++;
        pulse_abort();
        tick();
        mon0_en = 1'b0;
        mon_en  = 1'b1;
    endtask

    task automatic test_arm_abort();
        pulse_arm();
        rec(48'hC000_0001_0001, 1'b1, 1'b1, 1'b0);
        total++; if (state !== 2'b10) $display("FAIL aa_trig got %b want 10", state); else passed++;
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        total++; if (state !== 2'b00) $display("FAIL aa_state got %b want 00", state); else passed++;
        rec(48'hC000_0002_0002, 1'b0, 1'b0, 1'b0);
        rec(48'hC000_0003_0003, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (dropped !== 16'd2) $display("FAIL aa_dropped got %0d want 2", dropped); else passed++;
        total++; if (state !== 2'b00) $display("FAIL aa_stay_idle got %b want 00", state); else passed++;
    endtask

    task automatic test_back_to_back_restart();
        pulse_arm();
        rec(48'hD000_0001_0001, 1'b1, 1'b1, 1'b0);
        rec(48'hD000_0002_0002, 1'b0, 1'b1, 1'b0);
        arm = 1'b1;
        rec(48'hD000_0003_0003, 1'b1, 1'b1, 1'b0);
        arm = 1'b0;
        total++; if (state !== 2'b10) $display("FAIL rs_retrig got %b want 10", state); else passed++;
        rec(48'hD000_0004_0004, 1'b0, 1'b1, 1'b0);
        total++; if (state !== 2'b10) $display("FAIL rs_post1 got %b want 10", state); else passed++;
        rec(48'hD000_0005_0005, 1'b0, 1'b1, 1'b0);
        total++; if (state !== 2'b11) $display("FAIL rs_done got %b want 11", state); else passed++;
        tick();
        total++; if (q.size() != 0) $display("FAIL rs_missing got %0d pending want 0", q.size()); else passed++;
    endtask

    task automatic test_saturate();
        pulse_abort();
        in_data   = 48'hE000_0000_0000;
        in_enable = 1'b1;
        repeat (70000) @(posedge clock);
        #1;
        in_enable = 1'b0;
        tick();
        total++; if (dropped !== 16'hFFFF) $display("FAIL sat_dropped got %h want FFFF", dropped); else passed++;
        pulse_arm();
        total++; if (dropped !== 16'h0) $display("FAIL sat_arm_clear got %h want 0", dropped); else passed++;
    endtask

    task automatic test_reset_mid();
        rec(48'hF000_0001_0001, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        #1;
        in_data   = 48'hF000_0002_0002;
        in_enable = 1'b1;
        reset     = 1'b0;
        #1;
        total++; if (state !== 2'b00) $display("FAIL rm_state got %b want 00", state); else passed++;
        total++; if (out_enable !== 1'b0) $display("FAIL rm_out_enable got %b want 0", out_enable); else passed++;
        total++; if (out_data !== 48'h0) $display("FAIL rm_out_data got %h want 0", out_data); else passed++;
        tick();
        reset     = 1'b1;
        in_enable = 1'b0;
        repeat (3) tick();
        total++; if (state !== 2'b00) $display("FAIL rm_after got %b want 00", state); else passed++;
        total++; if (dropped !== 16'd0) $display("FAIL rm_dropped got %0d want 0", dropped); else passed++;
    endtask

    task automatic test_filter();
        pulse_arm();
`ifdef CAPTURE_FILTER_EN
        rec(48'h1111_2222_3304, 1'b1, 1'b0, 1'b0);
        total++; if (state !== 2'b01) $display("FAIL flt_masked got %b want 01", state); else passed++;
        total++; if (dropped !== 16'd0) $display("FAIL flt_no_drop got %0d want 0", dropped); else passed++;
        rec(48'h1111_2222_3302, 1'b1, 1'b1, 1'b0);
        total++; if (state !== 2'b10) $display("FAIL flt_pass got %b want 10", state); else passed++;
`else
        rec(48'h1111_2222_3304, 1'b1, 1'b1, 1'b0);
        total++; if (state !== 2'b10) $display("FAIL nofilt_trig got %b want 10", state); else passed++;
        rec(48'h1111_2222_3302, 1'b0, 1'b1, 1'b0);
        total++; if (state !== 2'b10) $display("FAIL nofilt_post got %b want 10", state); else passed++;
`endif
        tick();
        total++; if (q.size() != 0) $display("FAIL flt_missing got %0d pending want 0", q.size()); else passed++;
    endtask

    initial begin
        reset     = 1'b0;
        arm       = 1'b0;
        abort     = 1'b0;
        in_data   = '0;
        in_enable = 1'b0;
        trigger   = 1'b0;
        test_reset();
        test_idle_drop();
        test_capture();
        test_post0();
        test_arm_abort();
        test_back_to_back_restart();
        test_saturate();
        test_reset_mid();
        test_filter();
        repeat (2) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
